// File: rtl/wb_decoder_pkg.sv
// =============================================================================
// Module   : wb_decoder_pkg
// Purpose  : Shared types and constants for the four-slave Wishbone decoder.
// Revision : 1.0
// =============================================================================
`default_nettype none

package wb_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   typedef logic [1:0] slv_idx_t;

   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
   localparam int          CNT_W    = 8;

endpackage

`default_nettype wire

// File: rtl/wb_addr_match.sv
// =============================================================================
// Module   : wb_addr_match
// Purpose  : Priority compare of the address top byte against four slave bases.
// Revision : 1.0
// =============================================================================
`default_nettype none

module wb_addr_match
   import wb_decoder_pkg::*;
#(
   parameter logic [7:0] S0_ADDR = 8'h00,
   parameter logic [7:0] S1_ADDR = 8'h01,
   parameter logic [7:0] S2_ADDR = 8'h02,
   parameter logic [7:0] S3_ADDR = 8'h03
) (
   input  logic [7:0] adr_hi_i,
   output logic       hit_o,
   output slv_idx_t   idx_o
);

   localparam logic [7:0] BASES [4] = '{S0_ADDR, S1_ADDR, S2_ADDR, S3_ADDR};

   logic [3:0] match;

   for (genvar i = 0; i < 4; i++) begin : g_cmp
      assign match[i] = (adr_hi_i == BASES[i]);
   end

   // Scanning downwards lets the lowest matching index overwrite higher ones.
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int i = 3; i >= 0; i--) begin
         if (match[i]) begin
            hit_o = 1'b1;
            idx_o = slv_idx_t'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/wishbone_slave_decoder_4.sv
// =============================================================================
// Module   : wishbone_slave_decoder_4
// Purpose  : One-master to four-slave Wishbone router with error termination.
//            Optional watchdog enabled by defining WB_DECODER_TIMEOUT_EN.
// Revision : 1.0
// =============================================================================
`default_nettype none

module wishbone_slave_decoder_4 #(
   parameter logic [7:0]  S0_ADDR        = 8'h00,
   parameter logic [7:0]  S1_ADDR        = 8'h01,
   parameter logic [7:0]  S2_ADDR        = 8'h02,
   parameter logic [7:0]  S3_ADDR        = 8'h03,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_we_i,
   input  logic        m_cyc_i,
   input  logic        m_stb_i,
   input  logic [3:0]  m_sel_i,
   input  logic [31:0] m_adr_i,
   input  logic [31:0] m_dat_i,
   output logic [31:0] m_dat_o,
   output logic        m_ack_o,
   output logic        m_int_o,
   output logic        bus_err_o,
   output logic        s0_we_o,  s0_cyc_o, s0_stb_o,
   output logic [3:0]  s0_sel_o,
   output logic [31:0] s0_adr_o, s0_dat_o,
   input  logic [31:0] s0_dat_i,
   input  logic        s0_ack_i, s0_int_i,
   output logic        s1_we_o,  s1_cyc_o, s1_stb_o,
   output logic [3:0]  s1_sel_o,
   output logic [31:0] s1_adr_o, s1_dat_o,
   input  logic [31:0] s1_dat_i,
   input  logic        s1_ack_i, s1_int_i,
   output logic        s2_we_o,  s2_cyc_o, s2_stb_o,
   output logic [3:0]  s2_sel_o,
   output logic [31:0] s2_adr_o, s2_dat_o,
   input  logic [31:0] s2_dat_i,
   input  logic        s2_ack_i, s2_int_i,
   output logic        s3_we_o,  s3_cyc_o, s3_stb_o,
   output logic [3:0]  s3_sel_o,
   output logic [31:0] s3_adr_o, s3_dat_o,
   input  logic [31:0] s3_dat_i,
   input  logic        s3_ack_i, s3_int_i
);

   import wb_decoder_pkg::*;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   state_t      state_q, state_d;
   slv_idx_t    sel_q, sel_d;
   logic        int_q, int_d;
   logic        hit;
   slv_idx_t    hit_idx;
   logic        timeout;
   logic [3:0]  slv_en;
   logic [3:0]  s_ack;
   logic [31:0] s_dat [4];
   logic        sel_ack;
   logic [31:0] sel_dat;
   logic [31:0] fwd_adr;

   wb_addr_match #(
      .S0_ADDR (S0_ADDR),
      .S1_ADDR (S1_ADDR),
      .S2_ADDR (S2_ADDR),
      .S3_ADDR (S3_ADDR)
   ) u_match (
      .adr_hi_i (m_adr_i[31:24]),
      .hit_o    (hit),
      .idx_o    (hit_idx)
   );

   assign s_ack    = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
   assign s_dat[0] = s0_dat_i;
   assign s_dat[1] = s1_dat_i;
   assign s_dat[2] = s2_dat_i;
   assign s_dat[3] = s3_dat_i;
   assign sel_ack  = s_ack[sel_q];
   assign sel_dat  = s_dat[sel_q];
   assign int_d    = s0_int_i | s1_int_i | s2_int_i | s3_int_i;
   assign m_int_o  = int_q;

`ifdef WB_DECODER_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (state_q == ST_BUSY) && (cnt_q == TIMEOUT_VAL);

   // Counts stalled strobe cycles; any path out of BUSY leaves it at zero.
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_BUSY && !timeout && (m_cyc_i || sel_ack)) begin
         if (sel_ack)      cnt_d = '0;
         else if (m_stb_i) cnt_d = cnt_q + 1'b1;
         else              cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      slv_en    = 4'b0000;
      m_ack_o   = 1'b0;
      m_dat_o   = 32'h0;
      bus_err_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               if (hit) begin
                  state_d = ST_BUSY;
                  sel_d   = hit_idx;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            if (timeout) begin
               state_d = ST_ERR;
            end else begin
               slv_en[sel_q] = 1'b1;
               m_ack_o       = sel_ack;
               m_dat_o       = sel_dat;
               if (!m_cyc_i && !sel_ack) state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            m_ack_o   = m_stb_i;
            m_dat_o   = ERR_DATA;
            bus_err_o = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         int_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         int_q   <= int_d;
      end
   end

   // Slaves see the master bus with the top address byte stripped.
   assign fwd_adr = {8'h00, m_adr_i[23:0]};

   assign s0_we_o  = slv_en[0] & m_we_i;
   assign s0_cyc_o = slv_en[0] & m_cyc_i;
   assign s0_stb_o = slv_en[0] & m_stb_i;
   assign s0_sel_o = slv_en[0] ? m_sel_i : 4'h0;
   assign s0_adr_o = slv_en[0] ? fwd_adr : 32'h0;
   assign s0_dat_o = slv_en[0] ? m_dat_i : 32'h0;

   assign s1_we_o  = slv_en[1] & m_we_i;
   assign s1_cyc_o = slv_en[1] & m_cyc_i;
   assign s1_stb_o = slv_en[1] & m_stb_i;
   assign s1_sel_o = slv_en[1] ? m_sel_i : 4'h0;
   assign s1_adr_o = slv_en[1] ? fwd_adr : 32'h0;
   assign s1_dat_o = slv_en[1] ? m_dat_i : 32'h0;

   assign s2_we_o  = slv_en[2] & m_we_i;
   assign s2_cyc_o = slv_en[2] & m_cyc_i;
   assign s2_stb_o = slv_en[2] & m_stb_i;
   assign s2_sel_o = slv_en[2] ? m_sel_i : 4'h0;
   assign s2_adr_o = slv_en[2] ? fwd_adr : 32'h0;
   assign s2_dat_o = slv_en[2] ? m_dat_i : 32'h0;

   assign s3_we_o  = slv_en[3] & m_we_i;
   assign s3_cyc_o = slv_en[3] & m_cyc_i;
   assign s3_stb_o = slv_en[3] & m_stb_i;
   assign s3_sel_o = slv_en[3] ? m_sel_i : 4'h0;
   assign s3_adr_o = slv_en[3] ? fwd_adr : 32'h0;
   assign s3_dat_o = slv_en[3] ? m_dat_i : 32'h0;

endmodule

`default_nettype wire
